// File: rtl/iomem_mem_timer_bridge.sv
// iomem slave bridging the soc iomem port to main memory (with emulated access
// latency) and a 64-bit mtime/mtimecmp machine timer; unmapped accesses get a bus error.
//
// state    | meaning
// IDLE     | waiting for a request; the accept cycle issues the single RAM strobe
// RAM_WAIT | counting down the emulated RAM latency; ready when the counter hits 0
// TMR_RESP | timer access done at accept; ready with the registered read data
// ERR_RESP | unmapped access; ready together with bus_err_o
// DONE     | one dead cycle so a slow-dropping valid is never re-accepted
module iomem_mem_timer_bridge #(
  parameter logic [31:0] RAM_BASE_ADDR   = 32'h4000_0000,
  parameter logic [31:0] RAM_MASK_ADDR   = 32'h000f_ffff,
  parameter logic [31:0] TIMER_BASE_ADDR = 32'h3000_0000,
  parameter int unsigned RD_LATENCY      = 16,
  parameter int unsigned WR_LATENCY      = 4
) (
  input  logic        clk_used,
  input  logic        rst_n,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        mem_rd_en,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        timer_irq_o,
  output logic        bus_err_o
);

  localparam int unsigned LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W = $clog2(LAT_MAX);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM_WAIT,
    ST_TMR_RESP,
    ST_ERR_RESP,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic             cap_q, cap_d;
  logic [31:0]      hold_q, hold_d;

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      tmr_rdata_q, tmr_rdata_d;
  logic             irq_q;

  logic             ram_hit;
  logic             tmr_hit;
  logic             req_rd;
  logic             accept;
  logic             ram_acc;
  logic             tmr_acc;
  logic [1:0]       tmr_off;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    merge_bytes = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merge_bytes[8*i +: 8] = new_v[8*i +: 8];
    end
  endfunction

  assign ram_hit = (iomem_addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR;
  assign tmr_hit = (iomem_addr & ~32'hF) == TIMER_BASE_ADDR;
  assign req_rd  = (iomem_wstrb == 4'b0000);
  assign tmr_off = iomem_addr[3:2];
  assign accept  = rst_n && (state_q == ST_IDLE) && iomem_valid;
  assign ram_acc = accept && ram_hit;
  assign tmr_acc = accept && !ram_hit && tmr_hit;

  always_ff @(posedge clk_used) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (iomem_valid) begin
          if (ram_hit)      state_d = ST_RAM_WAIT;
          else if (tmr_hit) state_d = ST_TMR_RESP;
          else              state_d = ST_ERR_RESP;
        end
      end
      ST_RAM_WAIT: if (cnt_q == '0) state_d = ST_DONE;
      ST_TMR_RESP: state_d = ST_DONE;
      ST_ERR_RESP: state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    iomem_ready = 1'b0;
    iomem_rdata = '0;
    bus_err_o   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wstrb   = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (ram_acc) begin
          mem_rd_en = req_rd;
          mem_wstrb = iomem_wstrb;
        end
      end
      ST_RAM_WAIT: begin
        if (cnt_q == '0) begin
          iomem_ready = 1'b1;
          iomem_rdata = rd_q ? hold_q : 32'h0;
        end
      end
      ST_TMR_RESP: begin
        iomem_ready = 1'b1;
        iomem_rdata = tmr_rdata_q;
      end
      ST_ERR_RESP: begin
        iomem_ready = 1'b1;
        bus_err_o   = 1'b1;
      end
      default: ;
    endcase
  end

  // RAM data is only valid the cycle after the strobe, so cap_q marks that one cycle.
  always_comb begin
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    cap_d  = 1'b0;
    hold_d = hold_q;
    if (ram_acc) begin
      cnt_d = req_rd ? RD_LOAD : WR_LOAD;
      rd_d  = req_rd;
      cap_d = req_rd;
    end else if ((state_q == ST_RAM_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (cap_q) hold_d = mem_rdata;
  end

  always_ff @(posedge clk_used) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rd_q   <= 1'b0;
      cap_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      cap_q  <= cap_d;
      hold_q <= hold_d;
    end
  end

  // Timer access happens at accept; a write to mtime replaces that cycle's increment.
  always_comb begin
    mtime_d     = mtime_q + 64'd1;
    mtimecmp_d  = mtimecmp_q;
    shadow_d    = shadow_q;
    tmr_rdata_d = tmr_rdata_q;
    if (tmr_acc) begin
      tmr_rdata_d = '0;
      if (req_rd) begin
        case (tmr_off)
          2'd0: begin
            tmr_rdata_d = mtime_q[31:0];
            shadow_d    = mtime_q[63:32];
          end
          2'd1:    tmr_rdata_d = shadow_q;
          2'd2:    tmr_rdata_d = mtimecmp_q[31:0];
          default: tmr_rdata_d = mtimecmp_q[63:32];
        endcase
      end else begin
        case (tmr_off)
          2'd0: mtime_d = {mtime_q[63:32],
                           merge_bytes(mtime_q[31:0], iomem_wdata, iomem_wstrb)};
          2'd1: mtime_d = {merge_bytes(mtime_q[63:32], iomem_wdata, iomem_wstrb),
                           mtime_q[31:0]};
          2'd2: mtimecmp_d = {mtimecmp_q[63:32],
                              merge_bytes(mtimecmp_q[31:0], iomem_wdata, iomem_wstrb)};
          default: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], iomem_wdata, iomem_wstrb),
                                 mtimecmp_q[31:0]};
        endcase
      end
    end
  end

  always_ff @(posedge clk_used) begin
    if (!rst_n) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      shadow_q    <= '0;
      tmr_rdata_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      shadow_q    <= shadow_d;
      tmr_rdata_q <= tmr_rdata_d;
      irq_q       <= (mtime_q >= mtimecmp_q);
    end
  end

  assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_iomem_mem_timer_bridge.sv
// Bench for iomem_mem_timer_bridge: table vectors, timer/reset corner sequences and
// randomized traffic checked against a cycle-level behavioural model of the bus and timer.
module tb_iomem_mem_timer_bridge;

  localparam int RD_LAT = 16;
  localparam int WR_LAT = 4;

  logic        clk_used = 1'b0;
  logic        rst_n;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        mem_rd_en;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        timer_irq_o;
  logic        bus_err_o;

  always #5 clk_used = ~clk_used;

  iomem_mem_timer_bridge #(
    .RD_LATENCY(RD_LAT),
    .WR_LATENCY(WR_LAT)
  ) dut (
    .clk_used    (clk_used),
    .rst_n       (rst_n),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .mem_rd_en   (mem_rd_en),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .timer_irq_o (timer_irq_o),
    .bus_err_o   (bus_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // behavioural timer model
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_shadow, m_tmr_rdata;
  logic        m_irq;
  bit          acc_tmr;
  bit          irq_chk;
  logic [31:0] ram_word;

  // values sampled at the last negedge
  logic        s_ready, s_err, s_rd, s_irq;
  logic [31:0] s_rdata;
  logic [3:0]  s_wstrb;
  logic [63:0] s_mtime;
  int          rd_pulses, wr_pulses;
  logic [3:0]  last_wstrb;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] word;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_rd;
    int          exp_wr;
    logic [3:0]  exp_wstrb;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~m) | (new_v & m);
  endfunction

  // 0 = RAM, 1 = timer, 2 = unmapped
  function automatic int region(input logic [31:0] a);
    if (a >= 32'h4000_0000 && a <= 32'h400F_FFFF) return 0;
    if (a >= 32'h3000_0000 && a <= 32'h3000_000F) return 1;
    return 2;
  endfunction

  task automatic model_edge();
    logic [1:0] off;
    logic       wr_mtime;
    if (!rst_n) begin
      m_mtime  = '0;
      m_cmp    = '1;
      m_shadow = '0;
      m_irq    = 1'b0;
    end else begin
      m_irq    = (m_mtime >= m_cmp);
      off      = iomem_addr[3:2];
      wr_mtime = 1'b0;
      if (acc_tmr && iomem_wstrb == 4'h0) begin
        case (off)
          2'd0: begin m_tmr_rdata = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
          2'd1: m_tmr_rdata = m_shadow;
          2'd2: m_tmr_rdata = m_cmp[31:0];
          default: m_tmr_rdata = m_cmp[63:32];
        endcase
      end else if (acc_tmr) begin
        case (off)
          2'd0: begin m_mtime[31:0] = bytes_merge(m_mtime[31:0], iomem_wdata, iomem_wstrb); wr_mtime = 1'b1; end
          2'd1: begin m_mtime[63:32] = bytes_merge(m_mtime[63:32], iomem_wdata, iomem_wstrb); wr_mtime = 1'b1; end
          2'd2: m_cmp[31:0] = bytes_merge(m_cmp[31:0], iomem_wdata, iomem_wstrb);
          default: m_cmp[63:32] = bytes_merge(m_cmp[63:32], iomem_wdata, iomem_wstrb);
        endcase
      end
      if (!wr_mtime) m_mtime = m_mtime + 64'd1;
    end
  endtask

  // One clock cycle: sample at negedge, advance the model at posedge, then drive RAM data.
  task automatic step();
    @(negedge clk_used);
    s_ready = iomem_ready;
    s_rdata = iomem_rdata;
    s_err   = bus_err_o;
    s_rd    = mem_rd_en;
    s_wstrb = mem_wstrb;
    s_irq   = timer_irq_o;
    s_mtime = m_mtime;
    if (mem_rd_en) rd_pulses++;
    if (mem_wstrb != 4'h0) begin
      wr_pulses++;
      last_wstrb = mem_wstrb;
    end
    if (irq_chk) check("irq", timer_irq_o, m_irq);
    @(posedge clk_used);
    model_edge();
    acc_tmr = 1'b0;
    #1;
    mem_rdata = s_rd ? ram_word : $urandom();
  endtask

  task automatic reset_dut();
    rst_n       = 1'b0;
    iomem_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // rmode: 0 = no rdata check, 1 = exp_rdata, 2 = timer model
  task automatic xact(input string name, input logic [31:0] addr, input logic [3:0] wstrb,
                      input logic [31:0] wdata, input logic [31:0] word, input int exp_lat,
                      input logic exp_err, input int rmode, input logic [31:0] exp_rdata,
                      input int exp_rd, input int exp_wr, input logic [3:0] exp_wstrb,
                      input int drop_after, output logic [31:0] rdata);
    int lat;
    ram_word    = word;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    iomem_valid = 1'b1;
    acc_tmr     = (region(addr) == 1);
    rd_pulses   = 0;
    wr_pulses   = 0;
    last_wstrb  = 4'h0;
    lat = 0;
    step();
    while (!s_ready && lat < 64) begin
      if (lat == drop_after) iomem_valid = 1'b0;
      lat++;
      step();
    end
    rdata = s_rdata;
    check({name, " latency"}, lat, exp_lat);
    check({name, " bus_err"}, s_err, exp_err);
    if (rmode == 1) check({name, " rdata"}, s_rdata, exp_rdata);
    else if (rmode == 2) check({name, " rdata"}, s_rdata, m_tmr_rdata);
    iomem_valid = 1'b0;
    step();
    check({name, " done-cycle ready"}, s_ready, 1'b0);
    check({name, " rd_en pulses"}, rd_pulses, exp_rd);
    check({name, " wstrb pulses"}, wr_pulses, exp_wr);
    check({name, " wstrb value"}, last_wstrb, exp_wstrb);
  endtask

  initial begin
    logic [31:0] rd;
    int          rdy_cnt;
    bit          seen;

    vecs[0] = '{"ram_rd",      32'h4000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, RD_LAT, 1'b0, 32'hDEAD_BEEF, 1, 0, 4'h0};
    vecs[1] = '{"ram_wr",      32'h4000_0004, 4'h3, 32'h1234_5678, 32'h0,         WR_LAT, 1'b0, 32'h0,         0, 1, 4'h3};
    vecs[2] = '{"unmapped_rd", 32'h5000_0000, 4'h0, 32'h0,         32'h0,         1,      1'b1, 32'h0,         0, 0, 4'h0};
    vecs[3] = '{"ram_top",     32'h400F_FFFC, 4'h0, 32'h0,         32'hCAFE_F00D, RD_LAT, 1'b0, 32'hCAFE_F00D, 1, 0, 4'h0};
    vecs[4] = '{"ram_end+1",   32'h4010_0000, 4'h0, 32'h0,         32'h0,         1,      1'b1, 32'h0,         0, 0, 4'h0};
    vecs[5] = '{"tmr_end+1",   32'h3000_0010, 4'h0, 32'h0,         32'h0,         1,      1'b1, 32'h0,         0, 0, 4'h0};
    vecs[6] = '{"below_tmr",   32'h2FFF_FFFC, 4'hF, 32'h0,         32'h0,         1,      1'b1, 32'h0,         0, 0, 4'h0};
    vecs[7] = '{"unmapped_wr", 32'h8000_0000, 4'hF, 32'hAAAA_5555, 32'h0,         1,      1'b1, 32'h0,         0, 0, 4'h0};
    vecs[8] = '{"ram_wr_all",  32'h4000_0100, 4'hF, 32'h0BAD_F00D, 32'h0,         WR_LAT, 1'b0, 32'h0,         0, 1, 4'hF};

    rst_n = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0; iomem_addr = '0; iomem_wdata = '0;
    mem_rdata = '0; ram_word = '0; acc_tmr = 1'b0; irq_chk = 1'b0;
    rd_pulses = 0; wr_pulses = 0; last_wstrb = 4'h0;

    step();
    step();
    check("reset ready", s_ready, 1'b0);
    check("reset rdata", s_rdata, 32'h0);
    check("reset mem_rd_en", s_rd, 1'b0);
    check("reset mem_wstrb", s_wstrb, 4'h0);
    check("reset bus_err", s_err, 1'b0);
    check("reset irq", s_irq, 1'b0);
    rst_n   = 1'b1;
    irq_chk = 1'b1;
    step();

    foreach (vecs[i])
      xact(vecs[i].name, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, vecs[i].word, vecs[i].exp_lat,
           vecs[i].exp_err, 1, vecs[i].exp_rdata, vecs[i].exp_rd, vecs[i].exp_wr, vecs[i].exp_wstrb, -1, rd);

    // valid dropped early: the read still completes with its ready
    xact("early_drop", 32'h4000_0040, 4'h0, 32'h0, 32'h5A5A_0F0F, RD_LAT, 1'b0, 1, 32'h5A5A_0F0F,
         1, 0, 4'h0, 2, rd);

    // tear-free lo/hi read across the 32-bit carry
    reset_dut();
    xact("t3 wr_hi", 32'h3000_0004, 4'hF, 32'h0, 32'h0, 1, 1'b0, 0, 32'h0, 0, 0, 4'h0, -1, rd);
    xact("t3 wr_lo", 32'h3000_0000, 4'hF, 32'hFFFF_FFFC, 32'h0, 1, 1'b0, 0, 32'h0, 0, 0, 4'h0, -1, rd);
    xact("t3 rd_lo", 32'h3000_0000, 4'h0, 32'h0, 32'h0, 1, 1'b0, 2, 32'h0, 0, 0, 4'h0, -1, rd);
    check("t3 lo value", rd, 32'hFFFF_FFFE);
    xact("t3 rd_hi", 32'h3000_0004, 4'h0, 32'h0, 32'h0, 1, 1'b0, 2, 32'h0, 0, 0, 4'h0, -1, rd);
    check("t3 hi shadow", rd, 32'h0);
    xact("t3 rd_lo2", 32'h3000_0000, 4'h0, 32'h0, 32'h0, 1, 1'b0, 2, 32'h0, 0, 0, 4'h0, -1, rd);
    xact("t3 rd_hi2", 32'h3000_0004, 4'h0, 32'h0, 32'h0, 1, 1'b0, 2, 32'h0, 0, 0, 4'h0, -1, rd);
    check("t3 hi after carry", rd, 32'h1);

    // compare interrupt
    reset_dut();
    xact("t4 cmp_hi", 32'h3000_000C, 4'hF, 32'h0, 32'h0, 1, 1'b0, 0, 32'h0, 0, 0, 4'h0, -1, rd);
    xact("t4 cmp_lo", 32'h3000_0008, 4'hF, 32'h20, 32'h0, 1, 1'b0, 0, 32'h0, 0, 0, 4'h0, -1, rd);
    xact("t4 mtime_lo", 32'h3000_0000, 4'hF, 32'h10, 32'h0, 1, 1'b0, 0, 32'h0, 0, 0, 4'h0, -1, rd);
    check("t4 irq before match", s_irq, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      step();
      if (s_irq) begin
        seen = 1'b1;
        check("t4 irq rise mtime", s_mtime, 64'h21);
      end
    end
    check("t4 irq rose", seen, 1'b1);
    xact("t4 clr_hi", 32'h3000_000C, 4'hF, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, 0, 32'h0, 0, 0, 4'h0, -1, rd);
    xact("t4 clr_lo", 32'h3000_0008, 4'hF, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, 0, 32'h0, 0, 0, 4'h0, -1, rd);
    step();
    check("t4 irq cleared", s_irq, 1'b0);

    // partial byte strobes on a timer register
    xact("strb wr", 32'h3000_0008, 4'b0110, 32'hAABB_CCDD, 32'h0, 1, 1'b0, 0, 32'h0, 0, 0, 4'h0, -1, rd);
    xact("strb rd", 32'h3000_0008, 4'h0, 32'h0, 32'h0, 1, 1'b0, 2, 32'h0, 0, 0, 4'h0, -1, rd);
    check("strb merged value", rd, 32'hFFBB_CCFF);

    // reset in cycle 5 of a RAM read
    ram_word = 32'h1111_2222;
    iomem_addr = 32'h4000_0020; iomem_wstrb = 4'h0; iomem_wdata = '0; iomem_valid = 1'b1;
    rd_pulses = 0; wr_pulses = 0; rdy_cnt = 0;
    for (int i = 0; i < 5; i++) begin step(); if (s_ready) rdy_cnt++; end
    rst_n = 1'b0;
    iomem_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin step(); if (s_ready) rdy_cnt++; end
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin step(); if (s_ready) rdy_cnt++; end
    check("rst_mid ready count", rdy_cnt, 0);
    check("rst_mid rd pulses", rd_pulses, 1);
    check("rst_mid wr pulses", wr_pulses, 0);
    xact("rst_mid next rd", 32'h4000_0030, 4'h0, 32'h0, 32'h7654_3210, RD_LAT, 1'b0, 1, 32'h7654_3210,
         1, 0, 4'h0, -1, rd);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int          k, rk, el, rm, erd, ewr, drop;
      logic [31:0] a, wd, wrd, er;
      logic [3:0]  ws, ews;
      logic        ee;
      k   = $urandom_range(0, 4);
      wd  = $urandom();
      wrd = $urandom();
      ws  = 4'h0;
      case (k)
        0: a = 32'h4000_0000 | ($urandom() & 32'h000F_FFFC);
        1: begin a = 32'h4000_0000 | ($urandom() & 32'h000F_FFFC); ws = 4'($urandom_range(1, 15)); end
        2: a = 32'h3000_0000 | (32'($urandom_range(0, 3)) << 2);
        3: begin a = 32'h3000_0000 | (32'($urandom_range(0, 3)) << 2); ws = 4'($urandom_range(1, 15)); end
        default: a = $urandom();
      endcase
      rk   = region(a);
      drop = ($urandom_range(0, 3) == 0) ? 1 : -1;
      er   = 32'h0;
      if (rk == 0) begin
        el = (ws == 4'h0) ? RD_LAT : WR_LAT; ee = 1'b0; rm = 1;
        erd = (ws == 4'h0) ? 1 : 0; ewr = (ws != 4'h0) ? 1 : 0; ews = ws;
        if (ws == 4'h0) er = wrd;
      end else if (rk == 1) begin
        el = 1; ee = 1'b0; rm = (ws == 4'h0) ? 2 : 0; erd = 0; ewr = 0; ews = 4'h0;
      end else begin
        el = 1; ee = 1'b1; rm = 1; erd = 0; ewr = 0; ews = 4'h0;
      end
      xact("rnd", a, ws, wd, wrd, el, ee, rm, er, erd, ewr, ews, drop, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
